pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It consumes the ID-stage decode outputs (`rs1`, `rs2`, `syscall_op`, `break_op`) and the EX-stage load, branch and memory-ready status. From these it generates per-stage stall, bubble and flush controls, the syscall/ebreak trap entry handshake, and a stall performance counter. It sits beside the decoder and drives the IF/ID and ID/EX pipeline-register enables.

## Interface
- `DRAIN_CYCLES`, default 3: cycles needed to retire instructions older than ID before trap entry; legal range 1..15.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `id_valid`  in  1  the IF/ID register holds a valid instruction.
- `id_pc`  in  32  PC of the instruction in ID.
- `id_rs1`, `id_rs2`  in  5  source registers from the decoder.
- `id_rs1_used`, `id_rs2_used`  in  1  the instruction in ID actually reads the corresponding source.
- `id_syscall_op`, `id_break_op`  in  1  decoder syscall / break flags.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_branch_taken`  in  1  a branch or jump in EX resolved taken.
- `mem_stall`  in  1  data memory is not ready this cycle.
- `trap_ack`  in  1  the trap logic has redirected the PC to the handler.
- `perf_clr`  in  1  synchronous clear of `stall_cnt`.
- `stall_if`, `stall_id`, `stall_ex`  out  1  hold the PC, IF/ID and ID/EX registers respectively.
- `bubble_ex`  out  1  load a NOP into ID/EX.
- `flush_if_id`  out  1  invalidate IF/ID.
- `trap_req`  out  1  trap entry request.
- `trap_cause`  out  2  trap cause: 01 = syscall, 10 = break, 00 = none.
- `trap_pc`  out  32  captured `id_pc` of the trapping instruction.
- `stall_cnt`  out  `CNT_W`  count of cycles with `stall_id` = 1.

## Operation
- The FSM has three states: RUN, DRAIN and TRAP. It also keeps a drain counter `dcnt` (4 bits).
- Stall, bubble and flush outputs are combinational from the state and the current inputs. `trap_req`, `trap_cause`, `trap_pc` and `stall_cnt` are registered.
- In RUN, conditions are evaluated in this priority order:
  1. `mem_stall`: `stall_if` = `stall_id` = `stall_ex` = 1. No bubble, no flush.
  2. `ex_branch_taken`: `flush_if_id` = 1 and `bubble_ex` = 1. This suppresses any load-use stall or trap start in the same cycle.
  3. Load-use hazard: `ex_mem_read` and `ex_rd` != 0 and `id_valid` and ((`id_rs1_used` and `id_rs1` == `ex_rd`) or (`id_rs2_used` and `id_rs2` == `ex_rd`)). Then `stall_if` = `stall_id` = 1 and `bubble_ex` = 1.
  4. `id_valid` and (`id_syscall_op` or `id_break_op`):
     - `stall_if` = `stall_id` = 1 and `bubble_ex` = 1.
     - Latch `trap_pc` = `id_pc` and the cause; break wins if both flags are set.
     - Load `dcnt` = `DRAIN_CYCLES` and go to DRAIN.
- A register of x0 never creates a hazard.
- In DRAIN, `stall_if` = `stall_id` = 1 and `bubble_ex` = 1 every cycle.
  - `dcnt` decrements only when `mem_stall` = 0.
  - When `dcnt` == 1 and `mem_stall` = 0, go to TRAP.
  - While `mem_stall` = 1, `stall_ex` = 1 and `dcnt` holds.
  - `ex_branch_taken` is ignored; older branches cannot be present in this state.
- In TRAP, `trap_req` = 1, `flush_if_id` = 1 and `bubble_ex` = 1; `stall_if` = 0.
  - On `trap_ack` = 1, go to RUN. `trap_req` and `trap_cause` clear on the same edge.
  - `trap_pc` holds until the next trap.
- `trap_ack` outside TRAP is ignored.
- `stall_cnt` update rule:
  - `perf_clr` sets it to 0; clear has priority over increment.
  - Otherwise it increments when `stall_id` = 1.
  - It saturates at all-ones.

## Timing
- Reset values:
  - State RUN, `dcnt` = 0.
  - `trap_req` = 0, `trap_cause` = 00, `trap_pc` = 0, `stall_cnt` = 0.
  - All combinational outputs are therefore 0 while `rst_n` = 0.
- Asserting `rst_n` low mid-DRAIN or mid-TRAP returns the FSM to RUN immediately, without waiting for a clock edge.
- Load-use stall lasts exactly 1 cycle. The load advances to MEM, and the next cycle's compare sees a non-load in EX.
- Trap latency:
  - A syscall sampled in ID at cycle t (no `mem_stall`) gives DRAIN during cycles t+1 .. t+`DRAIN_CYCLES`.
  - `trap_req` is first high in cycle t+1+`DRAIN_CYCLES`.
  - Each `mem_stall` cycle during DRAIN adds one cycle.
- `trap_req` stays high until the cycle in which `trap_ack` = 1, and is low the following cycle. A single-cycle ack is sufficient.
- No combinational path exists from `trap_ack` to `trap_req`.

## Test plan
- Load-use: with `ex_mem_read` = 1 and `ex_rd` = 5, drive `id_rs1` = 5 with `id_rs1_used` = 1. Required: one cycle of `stall_if` = `stall_id` = `bubble_ex` = 1, then 0 once `ex_mem_read` = 0. Repeating with `ex_rd` = 0 must produce no stall.
- Priority: in the same cycle, assert a load-use hazard, `ex_branch_taken` = 1 and `mem_stall` = 0. Required: `flush_if_id` = `bubble_ex` = 1 and `stall_id` = 0. Adding `mem_stall` = 1 must give only the three stall outputs.
- Syscall: at cycle 10, `id_syscall_op` = 1 with `id_pc` = 0x0000_0040 and `DRAIN_CYCLES` = 3. Required: `trap_req` rises at cycle 14 with `trap_cause` = 01 and `trap_pc` = 0x40. `trap_ack` at cycle 17 makes `trap_req` = 0 at cycle 18 and state RUN.
- Drain with memory stall: same as the syscall case, with `mem_stall` = 1 during cycles 12–13. Required: `trap_req` rises at cycle 16 and `stall_ex` = 1 during cycles 12–13.
- Both flags and reset: `id_syscall_op` = `id_break_op` = 1 gives `trap_cause` = 10. Pulsing `rst_n` low during DRAIN must immediately return all outputs to 0; `stall_cnt` is 0.
- Counter: force 70000 consecutive stall cycles with `CNT_W` = 16. Required: `stall_cnt` holds 0xFFFF. `perf_clr` together with a stall gives 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/bubble/flush sequencing and trap entry for the 5-stage RV32I core.
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   id_valid, id_pc                IF/ID holds a valid instruction, and its PC
//   id_rs1/rs2, id_rs1/rs2_used    decoder source registers and whether they are read
//   id_syscall_op, id_break_op     decoder trap flags
//   ex_mem_read, ex_rd             EX holds a load, and its destination register
//   ex_branch_taken                taken branch/jump resolved in EX
//   mem_stall                      data memory not ready this cycle
//   trap_ack                       trap logic has redirected the PC to the handler
//   perf_clr                       synchronous clear of stall_cnt
//   stall_if/id/ex                 hold PC, IF/ID, ID/EX
//   bubble_ex, flush_if_id         NOP into ID/EX, invalidate IF/ID
//   trap_req, trap_cause, trap_pc  registered trap entry request, cause (01 sys, 10 brk), PC
//   stall_cnt                      saturating count of cycles with stall_id = 1
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_syscall_op,
    input  logic             id_break_op,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_stall,
    input  logic             trap_ack,
    input  logic             perf_clr,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             trap_req,
    output logic [1:0]       trap_cause,
    output logic [31:0]      trap_pc,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, DRAIN, TRAP} state_t;
    state_t           state_q, state_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic             trap_req_q, trap_req_d;
    logic [1:0]       cause_q, cause_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use, trap_op;
    // x0 never carries a dependency, so ex_rd == 0 masks the compare
    assign load_use = ex_mem_read && ex_rd != 5'd0 && id_valid &&
                      ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    assign trap_op  = id_valid && (id_syscall_op || id_break_op);
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        trap_req_d  = trap_req_q;
        cause_d     = cause_q;
        pc_d        = pc_q;
        // gating on rst_n keeps every control low while reset is held
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                    end else if (ex_branch_taken) begin
                        flush_if_id = 1'b1;
                        bubble_ex   = 1'b1;
                    end else if (load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (trap_op) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        pc_d      = id_pc;
                        cause_d   = id_break_op ? 2'b10 : 2'b01;
                        dcnt_d    = 4'(DRAIN_CYCLES);
                        state_d   = DRAIN;
                    end
                end
                DRAIN: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    stall_ex  = mem_stall;
                    if (!mem_stall) begin
                        dcnt_d = dcnt_q - 4'd1;
                        if (dcnt_q == 4'd1) begin
                            state_d    = TRAP;
                            trap_req_d = 1'b1;
                        end
                    end
                end
                TRAP: begin
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                    if (trap_ack) begin
                        state_d    = RUN;
                        trap_req_d = 1'b0;
                        cause_d    = 2'b00;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end
    assign cnt_d = perf_clr ? '0 : (stall_id && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            dcnt_q     <= 4'd0;
            trap_req_q <= 1'b0;
            cause_q    <= 2'b00;
            pc_q       <= 32'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            trap_req_q <= trap_req_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
        end
    end
    assign trap_req   = trap_req_q;
    assign trap_cause = cause_q;
    assign trap_pc    = pc_q;
    assign stall_cnt  = cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: self-checking bench for pipeline_ctrl with a trap-entry scoreboard.
module tb_pipeline_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, id_rs1_used, id_rs2_used, id_syscall_op, id_break_op;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_branch_taken, mem_stall, trap_ack, perf_clr;
    logic        stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, trap_req;
    logic [1:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [15:0] stall_cnt;
    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_syscall_op(id_syscall_op), .id_break_op(id_break_op),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_stall(mem_stall), .trap_ack(trap_ack), .perf_clr(perf_clr),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .trap_req(trap_req), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_run = 0;
    int n_fail = 0;
    typedef struct {
        logic [1:0]  cause;
        logic [31:0] pc;
        int          at;
    } trap_exp_t;
    trap_exp_t sb[$];
    // {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id}
    wire [4:0] ctl = {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    logic      trap_prev = 1'b0;
    trap_exp_t e;
    always @(negedge clk) begin
        if (trap_req && !trap_prev) begin
            if (sb.size() == 0) check("trap_req_spurious", trap_req, 0);
            else begin
                e = sb.pop_front();
                check("trap_cause", trap_cause, e.cause);
                check("trap_pc", trap_pc, e.pc);
                check("trap_rise_cycle", cyc, e.at);
            end
        end
        trap_prev <= trap_req;
    end
    task automatic idle();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_syscall_op = 0; id_break_op = 0; ex_mem_read = 0; ex_rd = 0;
        ex_branch_taken = 0; mem_stall = 0; trap_ack = 0; perf_clr = 0;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask
    task automatic hazard(input logic [4:0] r);
        ex_mem_read = 1; ex_rd = r; id_valid = 1; id_rs1 = r; id_rs1_used = 1;
    endtask
    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", ctl, 0);
        check("rst_trap_req", trap_req, 0);
        check("rst_cause", trap_cause, 0);
        check("rst_pc", trap_pc, 0);
        check("rst_cnt", stall_cnt, 0);
        rst_n = 1;
        step(); hazard(5); #1 check("lu_rs1", ctl, 5'b11010);
        step(); ex_rd = 5; id_valid = 1; id_rs1 = 5; id_rs1_used = 1; #1 check("lu_release", ctl, 0);
        check("lu_cnt", stall_cnt, 1);
        step(); ex_mem_read = 1; ex_rd = 7; id_valid = 1; id_rs1 = 7; id_rs2 = 7; id_rs2_used = 1;
        #1 check("lu_rs2", ctl, 5'b11010);
        step(); ex_mem_read = 1; ex_rd = 7; id_valid = 1; id_rs1 = 7; id_rs2 = 7;
        #1 check("lu_unused", ctl, 0);
        step(); hazard(0); #1 check("lu_x0", ctl, 0);
        step(); hazard(5); id_valid = 0; #1 check("lu_invalid", ctl, 0);
        step(); hazard(5); ex_branch_taken = 1; #1 check("prio_branch", ctl, 5'b00011);
        step(); hazard(5); ex_branch_taken = 1; mem_stall = 1; #1 check("prio_mem", ctl, 5'b11100);
        // syscall with plain drain; trap_ack in RUN must be ignored
        step(); perf_clr = 1; trap_ack = 1; #1 check("ack_in_run", ctl, 0);
        step(); id_valid = 1; id_syscall_op = 1; id_pc = 32'h40;
        sb.push_back('{2'b01, 32'h40, cyc + 4});
        #1 check("sys_enter", ctl, 5'b11010);
        for (int i = 1; i <= 3; i++) begin
            step(); ex_branch_taken = (i == 2); #1 check("sys_drain", ctl, 5'b11010);
            check("sys_drain_req", trap_req, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(); #1 check("sys_trap_ctl", ctl, 5'b00011);
            check("sys_trap_req", trap_req, 1);
        end
        step(); trap_ack = 1; #1 check("sys_ack_cycle", trap_req, 1);
        step(); #1 check("sys_req_clr", trap_req, 0);
        check("sys_cause_clr", trap_cause, 0);
        check("sys_pc_hold", trap_pc, 32'h40);
        check("sys_run_ctl", ctl, 0);
        check("sys_cnt", stall_cnt, 4);
        // syscall with two memory-stall cycles during drain
        step(); id_valid = 1; id_syscall_op = 1; id_pc = 32'h80;
        sb.push_back('{2'b01, 32'h80, cyc + 6});
        step(); #1 check("ms_drain1", ctl, 5'b11010);
        for (int i = 0; i < 2; i++) begin
            step(); mem_stall = 1; #1 check("ms_drain_stall", ctl, 5'b11110);
        end
        for (int i = 0; i < 2; i++) begin
            step(); #1 check("ms_drain_tail", ctl, 5'b11010);
            check("ms_drain_req", trap_req, 0);
        end
        step(); trap_ack = 1; #1 check("ms_trap_req", trap_req, 1);
        check("ms_trap_ctl", ctl, 5'b00011);
        step(); #1 check("ms_req_clr", trap_req, 0);
        // both flags: break wins
        step(); id_valid = 1; id_syscall_op = 1; id_break_op = 1; id_pc = 32'h1234;
        sb.push_back('{2'b10, 32'h1234, cyc + 4});
        step(); #1 check("both_cause_latched", trap_cause, 2'b10);
        repeat (2) step();
        step(); trap_ack = 1; #1 check("both_trap_req", trap_req, 1);
        step(); #1 check("both_req_clr", trap_req, 0);
        // asynchronous reset in the middle of drain
        step(); id_valid = 1; id_syscall_op = 1; id_pc = 32'h200;
        step(); step(); #1 check("rd_drain", ctl, 5'b11010);
        rst_n = 0;
        #1;
        check("rd_ctl", ctl, 0);
        check("rd_trap_req", trap_req, 0);
        check("rd_cause", trap_cause, 0);
        check("rd_pc", trap_pc, 0);
        check("rd_cnt", stall_cnt, 0);
        step(); rst_n = 1;
        repeat (6) step();
        #1 check("rd_run_ctl", ctl, 0);
        check("rd_no_trap", trap_req, 0);
        // counter saturation and clear priority
        for (int i = 0; i < 70000; i++) begin
            step(); mem_stall = 1;
        end
        step(); mem_stall = 1; perf_clr = 1; #1 check("cnt_sat", stall_cnt, 16'hffff);
        step(); mem_stall = 1; #1 check("cnt_clr", stall_cnt, 0);
        step(); #1 check("cnt_inc", stall_cnt, 1);
        step(); #1 check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
